div_seq_ctrl: RTL
=================

Name: div_seq_ctrl

Overview:
Sequencing front/back stage for the team's combinational divider (6-bit quotient, divide-by-zero flag).
- Accepts operand pairs over a valid/ready handshake.
- Drives the divider's dividend/divisor inputs from registers and waits a fixed number of settle cycles.
- Captures the quotient, computes the remainder, and presents the result over a valid/ready handshake.
- Divide-by-zero is resolved locally, without waiting on the divider.

Parameters:
- WIDTH, 6, operand/quotient/remainder width; must match the divider instance.
- SETTLE, 1, cycles operands are held on div_in1/div_in2 before quotient capture; a value of 0 behaves as 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  WIDTH  dividend.
- in_b  input  WIDTH  divisor.
- div_in1  output  WIDTH  registered dividend to divider.
- div_in2  output  WIDTH  registered divisor to divider.
- div_out  input  WIDTH  quotient from divider.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_q  output  WIDTH  quotient.
- out_r  output  WIDTH  remainder.
- out_dbz  output  1  divide-by-zero flag for this result.
- chk_err  output  1  quotient consistency error (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: in_ready=0 during reset, 1 on the first cycle after it deasserts. All other outputs are 0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - WAIT: operands driven, settle counter running, in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- IDLE transitions, on in_valid & in_ready at edge T:
  - Latch in_a→div_in1 and in_b→div_in2.
  - in_b≠0: load the settle counter with max(SETTLE,1), go to WAIT.
  - in_b=0: go straight to DONE with out_q = all ones (2^WIDTH−1), out_r = in_a, out_dbz=1. out_valid is seen at T+1.
- WAIT:
  - Counter decrements each cycle.
  - On the edge where the counter reaches 0: out_q←div_out, out_r←div_in1 − div_out*div_in2, out_dbz←0; go to DONE.
  - The product is formed at 2*WIDTH bits, then truncated to WIDTH.
  - Latency from accept edge T to out_valid: max(SETTLE,1)+1 cycles (SETTLE=1 → out_valid at T+2).
- DONE:
  - out_q, out_r, out_dbz and chk_err are held stable while out_valid=1 & out_ready=0.
  - On out_valid & out_ready: return to IDLE; out_valid=0 and in_ready=1 from the next cycle.
  - No accept in the same cycle as result handoff; peak throughput is one op per SETTLE+2 cycles.
- in_valid while in_ready=0 is ignored; in_a/in_b are not sampled.
- div_in1/div_in2 keep their last values after handoff; they change only on accept or reset.
- Reset mid-operation: state→IDLE, in-flight result discarded, outputs return to reset values.
- Arithmetic is unsigned throughout. out_r < out_b holds for a correct divider.

Optional Feature:
- Macro: DIV_CHECK_EN.
- Defined: at capture in WAIT, chk_err←1 if div_out*div_in2 > div_in1, or if the computed remainder ≥ div_in2. Otherwise chk_err←0.
  - chk_err is valid with out_valid and held the same way as the other result fields.
  - chk_err is always 0 for dbz results.
- Not defined: chk_err is tied to 0 and no check logic is built.

Test Plan:
- Basic divide, SETTLE=1: rst then in_a=45, in_b=7 accepted at T → out_valid at T+2 with out_q=6, out_r=3, out_dbz=0, chk_err=0.
- Divide by zero: in_a=5, in_b=0 accepted at T → out_valid at T+1, out_q=63, out_r=5, out_dbz=1; div_out is not used.
- Edge values: 63/1 → q=63, r=0. 3/9 → q=0, r=3. 7/7 → q=1, r=0. With SETTLE=3, out_valid arrives at accept+4.
- Backpressure: hold out_ready=0 for 5 cycles during 20/6 → out_q=3 and out_r=2 stable; in_ready=0 throughout; in_valid pulses are ignored. The first out_ready=1 completes the handoff and in_ready=1 on the next cycle.
- Reset in WAIT: assert rst one cycle after accepting 40/3 → next cycle out_valid=0, in_ready=0 then 1, all result outputs 0. No stale result appears afterwards.
- DIV_CHECK_EN with a faulty divider model (div_out forced to 7 for 45/7) → out_q=7, chk_err=1. Without the macro, chk_err=0.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// ---------------------------------------------------------------------------
// div_seq_ctrl
//
// Purpose:
//   Sequencing front/back stage around the team's combinational divider.
//   It accepts an operand pair over a valid/ready handshake and drives the
//   divider inputs from registers. It then waits a fixed number of settle
//   cycles and captures the quotient. It computes the remainder locally and
//   presents the result over a second valid/ready handshake. A zero divisor
//   is resolved here and the divider is never consulted for it.
//
// Parameters:
//   WIDTH   operand / quotient / remainder width (must match the divider)
//   SETTLE  cycles the operands are held before quotient capture (0 acts as 1)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand pair valid
//   in_ready   block can accept an operand pair
//   in_a       dividend
//   in_b       divisor
//   div_in1    registered dividend to the divider
//   div_in2    registered divisor to the divider
//   div_out    quotient from the divider
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_q      quotient
//   out_r      remainder
//   out_dbz    divide-by-zero flag for this result
//   chk_err    quotient consistency error
//
// Configuration macro:
//   DIV_CHECK_EN  when defined, the captured quotient is sanity-checked
//                 against the operands and chk_err reports an inconsistent
//                 divider. When undefined, chk_err is tied low and no check
//                 logic is built.
// ---------------------------------------------------------------------------
module div_seq_ctrl #(
  parameter int WIDTH  = 6,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] div_in1,
  output logic [WIDTH-1:0] div_in2,
  input  logic [WIDTH-1:0] div_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_dbz,
  output logic             chk_err
);

  // A settle time of zero still needs one cycle for the divider to see the
  // registered operands, so it is clamped to one.
  localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CNT_W      = $clog2(SETTLE_EFF + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   settle_cnt;
  logic [WIDTH-1:0]   remainder;

  // The remainder only needs the low WIDTH bits of quotient*divisor, because
  // unsigned subtraction wraps modulo 2^WIDTH. The consistency check needs
  // the full-width product to spot a quotient that overshoots the dividend.
`ifdef DIV_CHECK_EN
  logic [2*WIDTH-1:0] product;
  logic               chk_next;

  always_comb begin
    product   = {{WIDTH{1'b0}}, div_out} * {{WIDTH{1'b0}}, div_in2};
    remainder = div_in1 - product[WIDTH-1:0];
    chk_next  = (product > {{WIDTH{1'b0}}, div_in1}) || (remainder >= div_in2);
  end
`else
  logic [WIDTH-1:0] product;

  always_comb begin
    product   = div_out * div_in2;
    remainder = div_in1 - product;
  end

  assign chk_err = 1'b0;
`endif

  // Control FSM and all registered outputs. in_ready is a register, so it
  // reads 0 during reset and rises on the first edge after reset releases.
  // Accept and result handoff are never in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      in_ready   <= 1'b0;
      div_in1    <= '0;
      div_in2    <= '0;
      out_valid  <= 1'b0;
      out_q      <= '0;
      out_r      <= '0;
      out_dbz    <= 1'b0;
`ifdef DIV_CHECK_EN
      chk_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            div_in1  <= in_a;
            div_in2  <= in_b;
            in_ready <= 1'b0;
            if (in_b != '0) begin
              settle_cnt <= CNT_W'(SETTLE_EFF);
              state      <= WAIT;
            end else begin
              // Zero divisor: the answer is known without the divider.
              out_q     <= '1;
              out_r     <= in_a;
              out_dbz   <= 1'b1;
`ifdef DIV_CHECK_EN
              chk_err   <= 1'b0;
`endif
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end

        WAIT: begin
          settle_cnt <= settle_cnt - CNT_W'(1);
          if (settle_cnt == CNT_W'(1)) begin
            out_q     <= div_out;
            out_r     <= remainder;
            out_dbz   <= 1'b0;
`ifdef DIV_CHECK_EN
            chk_err   <= chk_next;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule
